// File: rtl/signed_shift_add_mult_pkg.sv
// signed_mult_pkg
// Shared definitions for the shift-add signed multiplier: controller state
// encoding, the default operand width and the iteration-counter width helper.
// No ports.
package signed_mult_pkg;

  localparam int DEFAULT_WORD_LENGTH = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    CALC     = 3'd2,
    FIX_SIGN = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Width of a counter that indexes 0..word_length-1; never narrower than 1.
  function automatic int count_width(input int word_length);
    return (word_length > 1) ? $clog2(word_length) : 1;
  endfunction

endpackage

// File: rtl/signed_shift_add_mult_if.sv
// signed_shift_add_mult_if
// Start/done request bus between a requester (register file, test FSM) and
// the shift-add multiplier.
//   start        requester -> multiplier  request, honoured only when idle
//   multiplicand requester -> multiplier  signed operand A
//   multiplier   requester -> multiplier  signed operand B
//   busy         multiplier -> requester  operation in progress
//   done         multiplier -> requester  one-cycle product-valid pulse
//   product      multiplier -> requester  signed 2*WORD_LENGTH result
interface signed_shift_add_mult_if #(
  parameter int WORD_LENGTH = signed_mult_pkg::DEFAULT_WORD_LENGTH
);
  logic                       start;
  logic [WORD_LENGTH-1:0]     multiplicand;
  logic [WORD_LENGTH-1:0]     multiplier;
  logic                       busy;
  logic                       done;
  logic [2*WORD_LENGTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/signed_shift_add_mult_mag_to_signed.sv
// mag_to_signed
// Combinational conditional two's-complement negation.
//   neg    in   1      negate when high
//   mag    in   WIDTH  unsigned magnitude (or two's-complement value)
//   value  out  WIDTH  neg ? -mag : mag
// Negation is its own inverse, so the same block also turns a signed operand
// into its magnitude when neg is the operand's sign bit. The most-negative
// value maps onto itself, which read as unsigned is the correct magnitude.
module mag_to_signed #(
  parameter int WIDTH = 8
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] mag,
  output logic [WIDTH-1:0] value
);

  assign value = neg ? (~mag + WIDTH'(1)) : mag;

endmodule

// File: rtl/signed_shift_add_mult.sv
// signed_shift_add_mult
// Sequential signed multiplier: sign/magnitude split, WORD_LENGTH cycles of
// shift-and-add on the magnitudes through one adder, then sign re-applied.
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of signed_shift_add_mult_if (start/operands in,
//          busy/done/product out)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start; operands captured on the accepting edge
// LOAD     | operand magnitudes and result sign registered, acc cleared
// CALC     | one partial product per cycle, WORD_LENGTH cycles
// FIX_SIGN | signed product registered from acc
// DONE     | done pulse, product valid; back to IDLE
module signed_shift_add_mult
  import signed_mult_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  signed_shift_add_mult_if.slave bus
);

  localparam int W  = WORD_LENGTH;
  localparam int CW = count_width(WORD_LENGTH);
  localparam logic [CW-1:0] LAST = CW'(WORD_LENGTH - 1);

  state_t          state, state_next;
  logic [W-1:0]    op_a, op_b;
  logic [W-1:0]    mag_a_in, mag_b_in;
  logic [W-1:0]    mag_a, mag_b;
  logic            neg;
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  partial;
  logic [2*W-1:0]  signed_acc;
  logic [2*W-1:0]  product_q;
  logic [CW-1:0]   count;

  mag_to_signed #(.WIDTH(W)) u_mag_a (
    .neg   (op_a[W-1]),
    .mag   (op_a),
    .value (mag_a_in)
  );

  mag_to_signed #(.WIDTH(W)) u_mag_b (
    .neg   (op_b[W-1]),
    .mag   (op_b),
    .value (mag_b_in)
  );

  mag_to_signed #(.WIDTH(2*W)) u_fix_sign (
    .neg   (neg),
    .mag   (acc),
    .value (signed_acc)
  );

  assign partial = {{W{1'b0}}, mag_a} << count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (bus.start) state_next = LOAD;
      LOAD:     state_next = CALC;
      CALC:     if (count == LAST) state_next = FIX_SIGN;
      FIX_SIGN: state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      mag_a     <= '0;
      mag_b     <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      count     <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a <= bus.multiplicand;
            op_b <= bus.multiplier;
          end
        end
        LOAD: begin
          mag_a <= mag_a_in;
          mag_b <= mag_b_in;
          neg   <= op_a[W-1] ^ op_b[W-1];
          acc   <= '0;
          count <= '0;
        end
        CALC: begin
          if (mag_b[0]) acc <= acc + partial;
          mag_b <= mag_b >> 1;
          count <= count + CW'(1);
        end
        FIX_SIGN: product_q <= signed_acc;
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_signed_shift_add_mult.sv
module tb_signed_shift_add_mult;

  localparam int W   = 8;
  localparam int LAT = W + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  signed_shift_add_mult_if #(.WORD_LENGTH(W)) bus();

  signed_shift_add_mult #(.WORD_LENGTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    string          name;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed integer multiplication, truncated to the product width.
  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[2*W-1:0];
  endfunction

  // Called at the negedge of the LOAD cycle (cycle 1 of an operation); returns at
  // the negedge of the done cycle or after a bounded wait.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.done && lat < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!bus.busy) busy_ok = 1'b0;
  endtask

  // Called at a negedge while idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                        output logic [2*W-1:0] prod, output int lat, output bit busy_ok);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.start        = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    wait_done(lat, busy_ok);
    prod = bus.product;
  endtask

  initial begin
    logic [2*W-1:0] prod, first;
    logic [W-1:0]   ra, rb;
    int             lat;
    bit             busy_ok, saw_done;

    tbl[0] = '{8'h07, 8'h03, 16'h0015, "7x3"};
    tbl[1] = '{8'hFB, 8'h03, 16'hFFF1, "-5x3"};
    tbl[2] = '{8'h80, 8'h80, 16'h4000, "-128x-128"};
    tbl[3] = '{8'h80, 8'h7F, 16'hC080, "-128x127"};
    tbl[4] = '{8'h00, 8'hFF, 16'h0000, "0x-1"};
    tbl[5] = '{8'hFF, 8'h00, 16'h0000, "-1x0"};
    tbl[6] = '{8'hFF, 8'hFF, 16'h0001, "-1x-1"};

    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;

    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_product", 32'(bus.product), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, 1'b0, prod, lat, busy_ok);
      check({tbl[i].name, "_product"}, 32'(prod), 32'(tbl[i].p));
      check({tbl[i].name, "_latency"}, 32'(lat), 32'(LAT));
      check({tbl[i].name, "_busy"}, 32'(busy_ok), 32'd1);
      @(negedge clk);
      check({tbl[i].name, "_done_pulse"}, 32'(bus.done), 32'd0);
      check({tbl[i].name, "_idle_busy"}, 32'(bus.busy), 32'd0);
      check({tbl[i].name, "_held"}, 32'(bus.product), 32'(tbl[i].p));
    end

    // start with new operands during CALC is ignored
    bus.multiplicand = 8'd9;
    bus.multiplier   = 8'hFE;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.multiplicand = 8'd100;
    bus.multiplier   = 8'd100;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 5;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("busy_start_product", 32'(bus.product), 32'(ref_product(8'd9, 8'hFE)));
    check("busy_start_latency", 32'(lat), 32'(LAT));
    @(negedge clk);
    check("busy_start_idle", 32'(bus.busy), 32'd0);
    run_op(8'd100, 8'd100, 1'b0, prod, lat, busy_ok);
    check("after_ignored_product", 32'(prod), 32'h2710);
    @(negedge clk);

    // back-to-back: start held through DONE is accepted in the following IDLE
    run_op(8'd12, 8'hF9, 1'b1, first, lat, busy_ok);
    check("b2b_first_product", 32'(first), 32'(ref_product(8'd12, 8'hF9)));
    bus.multiplicand = 8'hFD;
    bus.multiplier   = 8'd5;
    @(negedge clk);
    check("b2b_idle_busy", 32'(bus.busy), 32'd0);
    check("b2b_idle_held", 32'(bus.product), 32'(first));
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_accepted", 32'(bus.busy), 32'd1);
    wait_done(lat, busy_ok);
    check("b2b_second_latency", 32'(lat), 32'(LAT));
    check("b2b_second_product", 32'(bus.product), 32'(ref_product(8'hFD, 8'd5)));
    @(negedge clk);

    // reset during CALC
    bus.multiplicand = 8'h9C;
    bus.multiplier   = 8'h9C;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_product", 32'(bus.product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    run_op(8'h9C, 8'h9C, 1'b0, prod, lat, busy_ok);
    check("midrst_recover_product", 32'(prod), 32'h2710);
    check("midrst_recover_latency", 32'(lat), 32'(LAT));
    @(negedge clk);

    // randomized operands against the integer reference
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, 1'b0, prod, lat, busy_ok);
      check($sformatf("rand%0d_%0h_x_%0h", i, ra, rb), 32'(prod), 32'(ref_product(ra, rb)));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(LAT));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
